// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
//
// Multi-cycle sequencer for the 9-bit core. Owns the program counter, holds
// instruction decode off (init) whenever the core is not executing, and
// qualifies register-file (commit_en) and data-memory (mem_en) side effects so
// every instruction commits exactly once. Loads are stretched by MEM_LAT extra
// cycles. start/done handshake plus a saturating retired-instruction counter.
//
// Optional feature macro: SEQ_WATCHDOG_EN
//   Defined   -> per-run cycle watchdog of WATCHDOG_LIMIT cycles; on expiry the
//                run is forced to DONE with timeout=1.
//   Undefined -> no watchdog logic, timeout tied to 0.
//
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   one-cycle pulse, begins a run at PC 0 (IDLE/DONE only)
//   instruction    in   instruction word at pc (combinational fetch)
//   mem_read       in   decoded load
//   mem_write      in   decoded store
//   branch         in   decoded branch
//   branch_taken   in   ALU branch condition
//   branch_target  in   PC when the branch is taken
//   pc             out  registered program counter
//   init           out  decode hold-off, 1 whenever not executing
//   commit_en      out  register-write qualifier
//   mem_en         out  data-memory access qualifier
//   done           out  run finished (registered, sticky)
//   instr_count    out  retired instructions this run (saturating)
//   timeout        out  watchdog fired (registered, sticky)
//
// Handshake: start is sampled only in IDLE or DONE; a start seen there moves
// to EXEC on that edge, clearing pc, instr_count and done. done stays high
// until the next accepted start.
// -----------------------------------------------------------------------------
module core_sequencer #(
  parameter int          PC_W           = 10,
  parameter int          MEM_LAT        = 2,
  parameter logic [8:0]  HALT_INSTR     = 9'h1FF,
  parameter int          WATCHDOG_LIMIT = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [8:0]      instruction,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            branch,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] pc,
  output logic            init,
  output logic            commit_en,
  output logic            mem_en,
  output logic            done,
  output logic [15:0]     instr_count,
  output logic            timeout
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EXEC     = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  // Load wait counter preset: the EXEC cycle is the first of 1+MEM_LAT.
  localparam logic [3:0] WCNT_INIT = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;
  localparam bit         HAS_LAT   = (MEM_LAT > 0);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic            wd_fire;
  logic            running;
  logic            start_ok;
  logic [15:0]     cnt_inc;

  assign running  = (state_q == S_EXEC) || (state_q == S_MEM_WAIT);
  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    wcnt_d    = wcnt_q;
    init      = 1'b1;
    commit_en = 1'b0;
    mem_en    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_EXEC;
          pc_d    = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      S_EXEC: begin
        init = 1'b0;
        if (wd_fire) begin
          // Watchdog expiry: abandon the instruction with no side effect.
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (instruction == HALT_INSTR) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (mem_read && HAS_LAT) begin
          mem_en  = 1'b1;
          wcnt_d  = WCNT_INIT;
          state_d = S_MEM_WAIT;
        end else begin
          commit_en = 1'b1;
          mem_en    = mem_read | mem_write;
          cnt_d     = cnt_inc;
          pc_d      = (branch && branch_taken) ? branch_target : pc_q + 1'b1;
        end
      end
      S_MEM_WAIT: begin
        init = 1'b0;
        if (wd_fire) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          mem_en = 1'b1;
          if (wcnt_q != 4'd0) begin
            wcnt_d = wcnt_q - 4'd1;
          end else begin
            commit_en = 1'b1;
            pc_d      = pc_q + 1'b1;
            cnt_d     = cnt_inc;
            state_d   = S_EXEC;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      wcnt_q  <= wcnt_d;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  logic [31:0] wd_cnt_q;
  logic        timeout_q;

  // Fires in the WATCHDOG_LIMIT-th running cycle; the FSM leaves on that edge.
  assign wd_fire = running && (wd_cnt_q == 32'(WATCHDOG_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else if (start_ok) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else if (running) begin
      wd_cnt_q <= wd_cnt_q + 32'd1;
      if (wd_fire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  assign pc          = pc_q;
  assign done        = done_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_core_sequencer.sv
// -----------------------------------------------------------------------------
// tb_core_sequencer
//
// Directed bench for core_sequencer. A small program memory (indexed by pc)
// feeds instruction/mem_read/mem_write/branch/branch_target combinationally;
// branch_taken is driven directly. Outputs are sampled 2 time units after the
// rising edge. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_core_sequencer;

  localparam int         PC_W = 10;
  localparam logic [8:0] HALT = 9'h1FF;
  localparam logic [8:0] NOP  = 9'h000;
  localparam logic [8:0] ADD  = 9'h001;
  localparam logic [8:0] XORI = 9'h002;
  localparam logic [8:0] LW   = 9'h010;
  localparam logic [8:0] BEQ  = 9'h020;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start = 1'b0;
  logic            branch_taken = 1'b0;
  logic [8:0]      instruction;
  logic            mem_read, mem_write, branch;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] pc;
  logic            init, commit_en, mem_en, done, timeout;
  logic [15:0]     instr_count;

  logic [8:0]      prog  [0:15];
  logic            rd_a  [0:15];
  logic            wr_a  [0:15];
  logic            br_a  [0:15];
  logic [PC_W-1:0] tgt_a [0:15];

  assign instruction   = prog[pc[3:0]];
  assign mem_read      = rd_a[pc[3:0]];
  assign mem_write     = wr_a[pc[3:0]];
  assign branch        = br_a[pc[3:0]];
  assign branch_target = tgt_a[pc[3:0]];

  core_sequencer #(
    .PC_W(PC_W), .MEM_LAT(2), .HALT_INSTR(HALT), .WATCHDOG_LIMIT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instruction(instruction),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .init(init), .commit_en(commit_en), .mem_en(mem_en),
    .done(done), .instr_count(instr_count), .timeout(timeout)
  );

  // scoreboard counters
  int n_cmp = 0;
  int n_bad = 0;
  int commit_seen = 0;

  always @(posedge clk) if (commit_en === 1'b1) commit_seen++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) begin
      prog[i]  = HALT;
      rd_a[i]  = 1'b0;
      wr_a[i]  = 1'b0;
      br_a[i]  = 1'b0;
      tgt_a[i] = '0;
    end
  endtask

  // Start pulse is consumed on the next edge; first instruction is then live.
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [PC_W-1:0] e_pc,
                            input logic e_init, input logic e_commit, input logic e_mem);
    check_val({tag, ".pc"}, 32'(pc), 32'(e_pc));
    check_val({tag, ".init"}, 32'(init), 32'(e_init));
    check_val({tag, ".commit_en"}, 32'(commit_en), 32'(e_commit));
    check_val({tag, ".mem_en"}, 32'(mem_en), 32'(e_mem));
  endtask

  initial begin
    clear_prog();
    #12;
    // ---- reset state
    check_outs("rst", 0, 1, 0, 0);
    check_val("rst.done", 32'(done), 0);
    check_val("rst.count", 32'(instr_count), 0);
    check_val("rst.timeout", 32'(timeout), 0);
    rst_n = 1'b1;
    tick();
    check_outs("idle", 0, 1, 0, 0);

    // ---- {ADD, XOR, HALT}
    prog[0] = ADD; prog[1] = XORI; prog[2] = HALT;
    commit_seen = 0;
    do_start();
    check_outs("alu.c0", 0, 0, 1, 0);
    tick();
    check_outs("alu.c1", 1, 0, 1, 0);
    tick();
    check_outs("alu.halt", 2, 0, 0, 0);
    check_val("alu.done_pre", 32'(done), 0);
    tick();
    check_outs("alu.done", 2, 1, 0, 0);
    check_val("alu.done", 32'(done), 1);
    check_val("alu.count", 32'(instr_count), 2);
    check_val("alu.commits", 32'(commit_seen), 2);

    // ---- restart from DONE with {LW, HALT}
    clear_prog();
    prog[0] = LW; rd_a[0] = 1'b1; prog[1] = HALT;
    commit_seen = 0;
    do_start();
    check_val("rs.done", 32'(done), 0);
    check_val("rs.count", 32'(instr_count), 0);
    check_outs("lw.c0", 0, 0, 0, 1);
    tick();
    check_outs("lw.c1", 0, 0, 0, 1);
    tick();
    check_outs("lw.c2", 0, 0, 1, 1);
    tick();
    check_outs("lw.halt", 1, 0, 0, 0);
    tick();
    check_val("lw.done", 32'(done), 1);
    check_val("lw.count", 32'(instr_count), 1);
    check_val("lw.commits", 32'(commit_seen), 1);

    // ---- branch at pc 5, target 2; start ignored mid-run
    clear_prog();
    for (int i = 0; i < 5; i++) prog[i] = NOP;
    prog[5] = BEQ; br_a[5] = 1'b1; tgt_a[5] = 10'd2; prog[6] = HALT;
    branch_taken = 1'b1;
    do_start();
    tick(); tick();
    start = 1'b1;
    check_outs("br.pc2", 2, 0, 1, 0);
    tick();
    start = 1'b0;
    check_outs("br.ign_start", 3, 0, 1, 0);
    tick(); tick();
    check_val("br.at5", 32'(pc), 5);
    tick();
    check_val("br.taken", 32'(pc), 2);
    tick(); tick(); tick();
    check_val("br.at5b", 32'(pc), 5);
    branch_taken = 1'b0;
    tick();
    check_val("br.not_taken", 32'(pc), 6);
    tick();
    check_val("br.done", 32'(done), 1);
    check_val("br.count", 32'(instr_count), 10);

    // ---- reset during MEM_WAIT
    clear_prog();
    prog[0] = LW; rd_a[0] = 1'b1;
    do_start();
    commit_seen = 0;
    start = 1'b1;
    check_outs("ab.exec", 0, 0, 0, 1);
    tick();
    start = 1'b0;
    check_outs("ab.wait", 0, 0, 0, 1);
    check_val("ab.done", 32'(done), 0);
    rst_n = 1'b0;
    #1;
    check_outs("ab.rst", 0, 1, 0, 0);
    check_val("ab.count", 32'(instr_count), 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check_outs("ab.idle", 0, 1, 0, 0);
    check_val("ab.commits", 32'(commit_seen), 0);
    check_val("ab.timeout", 32'(timeout), 0);

`ifdef SEQ_WATCHDOG_EN
    // ---- self-loop, watchdog limit 16
    clear_prog();
    prog[0] = BEQ; br_a[0] = 1'b1; tgt_a[0] = 10'd0;
    branch_taken = 1'b1;
    do_start();
    for (int i = 0; i < 15; i++) tick();
    check_val("wd.pre_timeout", 32'(timeout), 0);
    check_val("wd.pre_init", 32'(init), 0);
    tick();
    check_val("wd.timeout", 32'(timeout), 1);
    check_val("wd.done", 32'(done), 1);
    check_val("wd.count", 32'(instr_count), 15);
    branch_taken = 1'b0;
    prog[0] = HALT;
    do_start();
    check_val("wd.clear", 32'(timeout), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
